// File: rtl/or_tree_pipe.sv
// Pipelined multi-lane OR reduction.
// Each lane reduces WIDTH bits through a balanced OR2 tree that is zero-padded
// to 2^LEVELS inputs. A register bank follows every REG_EVERY tree levels, so
// the result appears LAT advancing cycles after the sample is taken. A per-lane
// sticky accumulator collects every valid result until it is cleared.
module or_tree_pipe #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 2,
    parameter int REG_EVERY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic                   clr,
    output logic [LANES-1:0]       y,
    output logic                   out_valid,
    output logic [LANES-1:0]       ys
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int PADW   = 1 << LEVELS;
    localparam int LAT    = (LEVELS == 0) ? 1 : (LEVELS + REG_EVERY - 1) / REG_EVERY;

    // Number of tree levels already reduced once stage s (0-based count of
    // completed stages) has been passed.
    function automatic int levels_done(input int s);
        return (s * REG_EVERY < LEVELS) ? s * REG_EVERY : LEVELS;
    endfunction

    // Apply tree levels lo..hi-1 to a partially reduced vector. After level l
    // only the low PADW>>(l+1) bits carry partial ORs; the rest are forced to 0
    // so every stage register holds a clean, left-aligned set of partials.
    function automatic logic [PADW-1:0] or_levels(input logic [PADW-1:0] v,
                                                  input int lo, input int hi);
        logic [PADW-1:0] r;
        r = v;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= lo && l < hi) begin
                for (int i = 0; i < PADW / 2; i++) begin
                    if (i < (PADW >> (l + 1))) begin
                        r[i] = r[2*i] | r[2*i+1];
                    end
                end
                for (int i = 0; i < PADW; i++) begin
                    if (i >= (PADW >> (l + 1))) begin
                        r[i] = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    logic [LAT-1:0] valid_reg;
    logic           final_vin;

    // Valid bit travels alongside the data and freezes with it on a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else if (en) begin
            valid_reg[0] <= in_valid;
            for (int s = 1; s < LAT; s++) begin
                valid_reg[s] <= valid_reg[s-1];
            end
        end
    end

    assign out_valid = valid_reg[LAT-1];

    // Valid of the result that is about to be loaded into y on this edge.
    generate
        if (LAT == 1) begin : g_vin_direct
            assign final_vin = in_valid;
        end else begin : g_vin_piped
            assign final_vin = valid_reg[LAT-2];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PADW-1:0] stage_in   [LAT];
            logic [PADW-1:0] stage_next [LAT];
            logic [PADW-1:0] stage_reg  [LAT];
            logic            ys_reg;
            logic            acc_in;

            // Feed each stage from the previous register bank (stage 0 from
            // the zero-padded lane input) and reduce its share of levels.
            always_comb begin
                stage_in[0]              = '0;
                stage_in[0][WIDTH-1:0]   = a[gi*WIDTH +: WIDTH];
                for (int s = 1; s < LAT; s++) begin
                    stage_in[s] = stage_reg[s-1];
                end
                for (int s = 0; s < LAT; s++) begin
                    stage_next[s] = or_levels(stage_in[s], levels_done(s), levels_done(s + 1));
                end
            end

            // Data registers load on every advancing cycle, valid or not.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < LAT; s++) begin
                        stage_reg[s] <= '0;
                    end
                end else if (en) begin
                    for (int s = 0; s < LAT; s++) begin
                        stage_reg[s] <= stage_next[s];
                    end
                end
            end

            assign acc_in = stage_next[LAT-1][0];

            // Sticky accumulator: a clear coinciding with a new result keeps
            // that result; a clear on its own works even while stalled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ys_reg <= 1'b0;
                end else if (clr) begin
                    ys_reg <= en & final_vin & acc_in;
                end else if (en && final_vin) begin
                    ys_reg <= ys_reg | acc_in;
                end
            end

            assign y[gi]  = stage_reg[LAT-1][0];
            assign ys[gi] = ys_reg;
        end
    endgenerate

endmodule
